// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state encoding, mode constants and one-hot helper for onehot_decoder_seq
package decoder_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  localparam int MAX_OUT_W = 32;
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [4:0] sel);
    return MAX_OUT_W'(1) << sel;
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: loadable down-counter with decrement enable and zero flag
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered binary-to-one-hot decoder with handshake, hold and rotating scan
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      idx
);
  localparam int OUT_W = 2**SEL_W;
  state_t state, state_n;
  logic [OUT_W-1:0] y_n;
  logic [SEL_W-1:0] idx_n, pos, pos_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n, cnt;
  logic hs, load, dec, zero;
  assign in_ready = en && (state != SCAN);
  assign hs = in_valid && in_ready;
  assign y_valid = |y;
  dwell_counter #(.W(DWELL_W)) u_dwell (
    .clk(clk), .rst(rst), .load(load), .dec(dec),
    .load_val(hs ? dwell : dwell_r), .cnt(cnt), .zero(zero)
  );
  always_comb begin
    state_n = state;
    y_n = y;
    idx_n = idx;
    pos_n = pos;
    dwell_n = dwell_r;
    load = 1'b0;
    dec = 1'b0;
    if (!en) begin
      state_n = IDLE;
      y_n = '0;
      idx_n = '0;
    end else if (hs) begin
      y_n = OUT_W'(onehot(5'(sel)));
      idx_n = sel;
      state_n = (mode == MODE_SCAN) ? SCAN : HOLD;
      if (mode == MODE_SCAN) begin
        load = 1'b1;
        dwell_n = dwell;
        pos_n = '0;
      end
    end else if (state == SCAN) begin
      if (!zero) dec = 1'b1;
      else if (pos == '1) begin
        state_n = IDLE;
        y_n = '0;
        idx_n = '0;
      end else begin
        // rotate-left keeps y one-hot and idx tracks it with natural wrap
        y_n = {y[OUT_W-2:0], y[OUT_W-1]};
        idx_n = idx + SEL_W'(1);
        pos_n = pos + SEL_W'(1);
        load = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      y <= '0;
      idx <= '0;
      pos <= '0;
      dwell_r <= '0;
    end else begin
      state <= state_n;
      y <= y_n;
      idx <= idx_n;
      pos <= pos_n;
      dwell_r <= dwell_n;
    end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: scenario tasks plus randomized traffic against a sweep-timing reference model
module tb_onehot_decoder_seq;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [1:0] sel = '0, idx;
  logic [3:0] dwell = '0, y;
  logic in_ready, y_valid;
  int ncmp = 0, nfail = 0;
  logic [3:0] m_y = '0;
  logic [1:0] m_idx = '0;
  bit m_scan = 0;
  int m_t, m_d, m_start;

  onehot_decoder_seq #(.SEL_W(2), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .dwell(dwell), .y(y), .y_valid(y_valid), .idx(idx)
  );

  always #5 clk = ~clk;

  // position k of a sweep is shown for cycles k*(d+1) .. (k+1)*(d+1)-1 after the start
  task automatic tick();
    @(posedge clk);
    if (!en) begin
      m_y = '0; m_idx = '0; m_scan = 0;
    end else if (in_valid && !m_scan) begin
      m_idx = sel;
      m_y = 4'(1 << sel);
      if (mode) begin
        m_scan = 1; m_t = 0; m_start = int'(sel); m_d = int'(dwell);
      end
    end else if (m_scan) begin
      m_t++;
      if (m_t == 4 * (m_d + 1)) begin
        m_scan = 0; m_y = '0; m_idx = '0;
      end else begin
        m_idx = 2'((m_start + m_t / (m_d + 1)) % 4);
        m_y = 4'(1 << m_idx);
      end
    end
    #1;
  endtask

  task automatic model_reset();
    m_y = '0; m_idx = '0; m_scan = 0;
  endtask

  task automatic test_reset();
    #2;
    ncmp++;
    if (y !== 4'b0000 || idx !== 2'd0 || y_valid !== 1'b0) begin
      nfail++; $display("FAIL reset_init y=%b idx=%0d yv=%b want 0000/0/0", y, idx, y_valid);
    end
    @(negedge clk); rst = 1'b0; en = 1'b1;
    #1;
    ncmp++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    mode = 1'b1; sel = 2'd1; dwell = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    ncmp++;
    if (y !== 4'b0000 || idx !== 2'd0 || y_valid !== 1'b0) begin
      nfail++; $display("FAIL reset_async y=%b idx=%0d yv=%b want 0000/0/0", y, idx, y_valid);
    end
    #1 rst = 1'b0;
    #1;
    ncmp++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    tick();
    ncmp++;
    if (y !== 4'b0000 || in_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_idle y=%b rdy=%b want 0000/1", y, in_ready);
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      ncmp++;
      if (y !== exp[i] || y !== m_y || idx !== 2'(i) || y_valid !== 1'b1) begin
        nfail++; $display("FAIL direct_%0d y=%b idx=%0d yv=%b want %b/%0d/1", i, y, idx, y_valid, exp[i], i);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    ncmp++;
    if (y !== 4'b1000 || idx !== 2'd3) begin
      nfail++; $display("FAIL direct_hold y=%b idx=%0d want 1000/3", y, idx);
    end
  endtask

  task automatic test_scan_wrap();
    logic [3:0] exp [9] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    mode = 1'b1; sel = 2'd2; dwell = 4'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ncmp++;
      if (y !== exp[i] || y !== m_y || idx !== m_idx || y_valid !== (exp[i] != 0) || in_ready !== (i == 8)) begin
        nfail++; $display("FAIL scan_wrap_%0d y=%b idx=%0d rdy=%b want %b/%0d/%b", i, y, idx, in_ready, exp[i], m_idx, i == 8);
      end
      tick();
    end
  endtask

  task automatic test_scan_dwell0();
    logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    mode = 1'b1; sel = 2'd0; dwell = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ncmp++;
      if (y !== exp[i] || idx !== m_idx || y !== m_y) begin
        nfail++; $display("FAIL scan_dwell0_%0d y=%b idx=%0d want %b/%0d", i, y, idx, exp[i], m_idx);
      end
      tick();
    end
  endtask

  task automatic test_enable();
    int guard = 0;
    en = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 2'd2;
    #1;
    ncmp++;
    if (in_ready !== 1'b0) begin nfail++; $display("FAIL en_low_ready got %b want 0", in_ready); end
    tick(); tick();
    ncmp++;
    if (y !== 4'b0000 || y_valid !== 1'b0) begin nfail++; $display("FAIL en_low_y got %b want 0000", y); end
    en = 1'b1; mode = 1'b1; sel = 2'd0; dwell = 4'd2;
    tick();
    in_valid = 1'b0;
    while (m_y != 4'b1000 && guard < 20) begin tick(); guard++; end
    ncmp++;
    if (guard >= 20 || y !== 4'b1000) begin nfail++; $display("FAIL en_reach_pos3 y=%b want 1000", y); end
    en = 1'b0;
    #1;
    ncmp++;
    if (in_ready !== 1'b0) begin nfail++; $display("FAIL en_drop_ready got %b want 0", in_ready); end
    tick();
    ncmp++;
    if (y !== 4'b0000 || idx !== 2'd0 || y_valid !== 1'b0) begin
      nfail++; $display("FAIL en_drop_y y=%b idx=%0d want 0000/0", y, idx);
    end
    en = 1'b1;
    #1;
    ncmp++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL en_idle_ready got %b want 1", in_ready); end
    tick();
    ncmp++;
    if (y !== 4'b0000) begin nfail++; $display("FAIL en_idle_y got %b want 0000", y); end
  endtask

  task automatic test_back_to_back_busy();
    int waited = 0;
    bit acc = 0;
    mode = 1'b1; sel = 2'd1; dwell = 4'd1; in_valid = 1'b1;
    tick();
    mode = 1'b0; sel = 2'd3;
    while (!acc && waited < 20) begin
      acc = in_ready;
      ncmp++;
      if (in_ready !== (en && !m_scan)) begin
        nfail++; $display("FAIL busy_ready_%0d got %b want %b", waited, in_ready, en && !m_scan);
      end
      tick();
      if (!acc) waited++;
    end
    in_valid = 1'b0;
    ncmp++;
    if (waited != 8) begin nfail++; $display("FAIL busy_wait got %0d cycles want 8", waited); end
    ncmp++;
    if (y !== 4'b1000 || idx !== 2'd3) begin nfail++; $display("FAIL busy_accept y=%b idx=%0d want 1000/3", y, idx); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 15) != 0;
      in_valid = $urandom_range(0, 2) != 0;
      mode = $urandom_range(0, 3) == 0;
      sel = 2'($urandom_range(0, 3));
      dwell = 4'($urandom_range(0, 2));
      #1;
      ncmp++;
      if (in_ready !== (en && !m_scan)) begin
        nfail++; $display("FAIL rand_ready_%0d got %b want %b", i, in_ready, en && !m_scan);
      end
      tick();
      ncmp++;
      if (y !== m_y || idx !== m_idx || y_valid !== (m_y != 0)) begin
        nfail++; $display("FAIL rand_out_%0d y=%b idx=%0d yv=%b want %b/%0d/%b", i, y, idx, y_valid, m_y, m_idx, m_y != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_scan_dwell0();
    test_enable();
    test_back_to_back_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
